// File: rtl/load_unit.sv
// Load unit: issues one word-aligned memory read per request, then extracts,
// extends and registers a byte, halfword or word result.
`timescale 1ns/1ps
module load_unit #(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  LoadControl,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_out,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  // WAIT covers MEM_LATENCY-1 cycles; the counter runs 0..WAIT_LAST.
  localparam logic [3:0] WAIT_LAST = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

  state_t      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] load_out_q, load_out_d;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a_lo[0];
      SZ_WORD: bad = (a_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] extract(input logic [1:0]  size,
                                          input logic        sext,
                                          input logic [1:0]  lane,
                                          input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: res = sext ? 32'($signed(b)) : {24'd0, b};
      SZ_HALF: res = sext ? 32'($signed(h)) : {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    sext_d     = sext_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    load_out_d = load_out_q;
    mem_rd     = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    busy       = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          size_d = LoadControl;
          sext_d = sign_ext;
          lane_d = addr[1:0];
          if (misaligned(LoadControl, addr[1:0])) begin
            state_d = ERR;
          end else begin
            mem_addr_d = {addr[31:2], 2'b00};
            state_d    = REQ;
          end
        end
      end
      REQ: begin
        mem_rd  = 1'b1;
        cnt_d   = 4'd0;
        state_d = (MEM_LATENCY == 1) ? CAPT : WAIT;
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CAPT: begin
        load_out_d = extract(size_q, sext_q, lane_q, mem_rdata);
        state_d    = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        error   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      size_q     <= 2'd0;
      sext_q     <= 1'b0;
      lane_q     <= 2'd0;
      cnt_q      <= 4'd0;
      mem_addr_q <= 32'd0;
      load_out_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      load_out_q <= load_out_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign load_out = load_out_q;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: vector table through a scoreboard, plus hand-written
// sequences for restart-while-busy, mid-load reset and back-to-back loads.
`timescale 1ns/1ps
module tb_load_unit;
  localparam int ML = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  LoadControl;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] mem_rdata;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] load_out;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  load_unit #(.MEM_LATENCY(ML)) dut (
    .clk(clk), .reset(reset), .start(start), .LoadControl(LoadControl),
    .sign_ext(sign_ext), .addr(addr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .load_out(load_out), .busy(busy), .done(done),
    .error(error)
  );

  typedef struct {
    logic        is_err;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic [1:0]  lc;
    logic        sx;
    logic [31:0] a;
    logic [31:0] rdata;
    logic        exp_err;
    logic [31:0] exp_out;
    logic [31:0] exp_maddr;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  vec_t        vecs[12];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rd_count = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  int          overlap = 0;
  int          rd_cnt = 0;
  int          resp_cyc = 0;
  logic        resp_flag = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic [31:0] mem_word = 32'd0;

  // Memory model and response monitor: data is valid only in the cycle
  // that lies ML cycles after the read strobe.
  always begin
    @(negedge clk);
    if (done || error) begin
      resp_flag = 1'b1;
      resp_cyc  = cyc;
      if (done && error) overlap++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_response done=%0b error=%0b load_out=0x%08h required no response",
                 done, error, load_out);
      end else begin
        mon_e = sb_q.pop_front();
        if (error !== mon_e.is_err || load_out !== mon_e.val) begin
          failures++;
          $display("FAIL scoreboard actual error=%0b load_out=0x%08h required error=%0b load_out=0x%08h",
                   error, load_out, mon_e.is_err, mon_e.val);
        end
      end
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (mem_rd) begin
      rd_count++;
      rd_addr = mem_addr;
      rd_cnt  = ML;
    end
    @(posedge clk);
    cyc++;
    #1;
    mem_rdata = (rd_cnt == 1) ? mem_word : 32'hDEAD_BEEF;
    if (rd_cnt > 0) rd_cnt--;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_resp(input string tag);
    for (int i = 0; i < 40 && !resp_flag; i++) @(posedge clk);
    #1;
    if (!resp_flag) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no response required=response within 40 cycles", tag);
    end
  endtask

  task automatic run_load(input vec_t v, input string tag);
    int st;
    int rd0;
    @(posedge clk); #1;
    LoadControl = v.lc; sign_ext = v.sx; addr = v.a; mem_word = v.rdata; start = 1'b1;
    sb_q.push_back('{v.exp_err, v.exp_out});
    st = cyc; rd0 = rd_count; resp_flag = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; addr = 32'hFFFF_FFFF; LoadControl = 2'd0; sign_ext = ~v.sx;
    wait_resp(tag);
    if (resp_flag) begin
      chk({tag, "_latency"}, 32'(resp_cyc - st), v.exp_err ? 32'd1 : 32'(ML + 2));
      chk({tag, "_rd_count"}, 32'(rd_count - rd0), v.exp_err ? 32'd0 : 32'd1);
      if (!v.exp_err) chk({tag, "_mem_addr"}, rd_addr, v.exp_maddr);
    end
  endtask

  initial begin
    int d0;
    int e0;
    int rd0;
    int st;
    vec_t v;

    vecs[0]  = '{2'd1, 1'b1, 32'h0000_0103, 32'h80FF_1234, 1'b0, 32'hFFFF_FF80, 32'h0000_0100};
    vecs[1]  = '{2'd2, 1'b0, 32'h0000_0202, 32'h9ABC_5678, 1'b0, 32'h0000_9ABC, 32'h0000_0200};
    vecs[2]  = '{2'd2, 1'b1, 32'h0000_0200, 32'h1234_8001, 1'b0, 32'hFFFF_8001, 32'h0000_0200};
    vecs[3]  = '{2'd3, 1'b0, 32'h0000_0301, 32'h0BAD_0BAD, 1'b1, 32'hFFFF_8001, 32'h0};
    vecs[4]  = '{2'd1, 1'b0, 32'h0000_0100, 32'hAABB_CC7F, 1'b0, 32'h0000_007F, 32'h0000_0100};
    vecs[5]  = '{2'd1, 1'b1, 32'h0000_0101, 32'h0000_81FF, 1'b0, 32'hFFFF_FF81, 32'h0000_0100};
    vecs[6]  = '{2'd1, 1'b0, 32'h0000_0102, 32'h00C3_0000, 1'b0, 32'h0000_00C3, 32'h0000_0100};
    vecs[7]  = '{2'd3, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 32'h0000_0400};
    vecs[8]  = '{2'd0, 1'b1, 32'h0000_0500, 32'h1111_1111, 1'b1, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = '{2'd2, 1'b1, 32'h0000_0201, 32'h2222_2222, 1'b1, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{2'd2, 1'b1, 32'h1234_5606, 32'h7FFF_0000, 1'b0, 32'h0000_7FFF, 32'h1234_5604};
    vecs[11] = '{2'd1, 1'b1, 32'h0000_0000, 32'hFFFF_FF7F, 1'b0, 32'h0000_007F, 32'h0000_0000};

    reset = 1'b0; start = 1'b0; LoadControl = 2'd0; sign_ext = 1'b0;
    addr = 32'd0; mem_rdata = 32'hDEAD_BEEF;
    #23;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_error", {31'd0, error}, 32'd0);
    chk("reset_load_out", load_out, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    #4 reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_load(vecs[i], $sformatf("vec%0d", i));
    end

    // Restart pulsed during WAIT must be ignored.
    @(posedge clk); #1;
    LoadControl = 2'd3; sign_ext = 1'b0; addr = 32'h0000_0500; mem_word = 32'h1122_3344;
    sb_q.push_back('{1'b0, 32'h1122_3344});
    d0 = done_cnt; rd0 = rd_count; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("restart_busy_in_wait", {31'd0, busy}, 32'd1);
    LoadControl = 2'd1; addr = 32'h0000_0603; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("restart_rd_count", 32'(rd_count - rd0), 32'd1);
    chk("restart_done_count", 32'(done_cnt - d0), 32'd1);
    chk("restart_mem_addr_held", mem_addr, 32'h0000_0500);

    // Asynchronous reset in the middle of WAIT aborts the load.
    @(posedge clk); #1;
    LoadControl = 2'd1; sign_ext = 1'b0; addr = 32'h0000_0703; mem_word = 32'h5500_0000;
    d0 = done_cnt; e0 = err_cnt; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort_mem_rd_in_req", {31'd0, mem_rd}, 32'd1);
    @(posedge clk); #2;
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("abort_load_out", load_out, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_no_error", 32'(err_cnt - e0), 32'd0);
    v = '{2'd1, 1'b1, 32'h0000_0101, 32'h0000_FE00, 1'b0, 32'hFFFF_FFFE, 32'h0000_0100};
    run_load(v, "after_reset");

    // Back-to-back: second start in the IDLE cycle right after DONE.
    @(posedge clk); #1;
    LoadControl = 2'd2; sign_ext = 1'b1; addr = 32'h0000_0802; mem_word = 32'hF00D_8000;
    sb_q.push_back('{1'b0, 32'hFFFF_F00D});
    d0 = done_cnt; rd0 = rd_count; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("b2b_first_done", 32'(done_cnt - d0), 32'd1);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    LoadControl = 2'd1; sign_ext = 1'b0; addr = 32'h0000_0903; mem_word = 32'h5A00_0000;
    sb_q.push_back('{1'b0, 32'h0000_005A});
    st = cyc; resp_flag = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_resp("b2b_second");
    if (resp_flag) begin
      chk("b2b_second_latency", 32'(resp_cyc - st), 32'(ML + 2));
      chk("b2b_second_mem_addr", rd_addr, 32'h0000_0900);
    end
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    chk("b2b_rd_count", 32'(rd_count - rd0), 32'd2);

    repeat (3) @(posedge clk);
    #1;
    chk("done_error_overlap", 32'(overlap), 32'd0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 2, the number of cycles from the read-strobe cycle to valid mem_rdata; legal range 1..15.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, one-cycle load request, sampled only in IDLE.
REQ-005 The block SHALL have port LoadControl, input, 2, size code: 1 = byte, 2 = halfword, 3 = word, 0 = invalid.
REQ-006 The block SHALL have port sign_ext, input, 1, 1 = sign-extend, 0 = zero-extend; ignored for word.
REQ-007 The block SHALL have port addr, input, 32, byte address of the load.
REQ-008 The block SHALL have port mem_rd, output, 1, memory read strobe.
REQ-009 The block SHALL have port mem_addr, output, 32, word-aligned memory address.
REQ-010 The block SHALL have port mem_rdata, input, 32, word returned by memory.
REQ-011 The block SHALL have port load_out, output, 32, extracted and extended load result.
REQ-012 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse when load_out is updated.
REQ-014 The block SHALL have port error, output, 1, one-cycle pulse on a rejected request.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT, CAPT, DONE and ERR.
REQ-016 At the edge where start=1 in IDLE, the block SHALL latch LoadControl, sign_ext and addr.
- On that edge it SHALL go to ERR if LoadControl=0, or LoadControl=2 with addr[0]=1, or LoadControl=3 with addr[1:0]!=0.
- Otherwise it SHALL go to REQ.
REQ-017 REQ SHALL last exactly one cycle, with mem_rd=1 and mem_addr={addr[31:2],2'b00}, then go to WAIT.
REQ-018 mem_rd SHALL be 0 in every state other than REQ.
REQ-019 mem_addr SHALL hold its last value outside REQ; its reset value SHALL be 0.
REQ-020 WAIT SHALL last MEM_LATENCY-1 cycles using a 4-bit counter, then go to CAPT; with MEM_LATENCY=1 the block SHALL go directly from REQ to CAPT.
REQ-021 At the edge ending CAPT, the block SHALL register the extracted value into load_out and go to DONE.
- mem_rdata is valid in CAPT: CAPT is MEM_LATENCY cycles after REQ.
REQ-022 Byte extraction SHALL be little-endian, selecting lane addr[1:0]: 0 = [7:0], 1 = [15:8], 2 = [23:16], 3 = [31:24].
REQ-023 Halfword extraction SHALL select [15:0] when addr[1]=0 and [31:16] when addr[1]=1.
REQ-024 Byte and halfword results SHALL be extended to 32 bits, replicating the MSB when sign_ext=1 and zero-filling when sign_ext=0.
REQ-025 Word results SHALL be passed unchanged.
REQ-026 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-027 load_out SHALL hold its value until the next DONE.
REQ-028 Latency from the start edge to done high SHALL be MEM_LATENCY+2 cycles.
REQ-029 ERR SHALL assert error=1 for one cycle with no memory access and load_out unchanged, then return to IDLE.
REQ-030 start SHALL be ignored while busy=1; no queuing.
REQ-031 start may be asserted in the IDLE cycle immediately after DONE or ERR and SHALL be accepted.
REQ-032 done and error SHALL never be high in the same cycle.

Reset
REQ-033 While reset=0, the block SHALL force the FSM to IDLE immediately, without waiting for clk.
REQ-034 While reset=0, the block SHALL clear load_out, mem_addr, the latched request and the counter to 0.
REQ-035 While reset=0, the block SHALL drive mem_rd, busy, done and error to 0.
REQ-036 A reset during REQ, WAIT or CAPT SHALL abort the load with no done and no error.
- Any mem_rdata arriving later SHALL be ignored.
REQ-037 After reset release, the first accepted start SHALL behave as from power-up.

Verification
REQ-038 The bench SHALL cover these scenarios, with MEM_LATENCY=2:
- LoadControl=1, sign_ext=1, addr=0x103, mem_rdata=0x80FF_1234 -> mem_addr=0x100, load_out=0xFFFF_FF80, done 4 cycles after start.
- LoadControl=2, sign_ext=0, addr=0x202, mem_rdata=0x9ABC_5678 -> load_out=0x0000_9ABC.
- LoadControl=2, sign_ext=1, addr=0x200, mem_rdata=0x1234_8001 -> load_out=0xFFFF_8001.
- LoadControl=3, addr=0x301 -> error pulse 1 cycle after start, mem_rd never high, load_out unchanged.
- start re-pulsed during WAIT -> ignored, exactly one mem_rd and one done.
- reset=0 asserted mid-WAIT -> busy=0 and mem_rd=0 immediately, no done.
- Back-to-back: a new start in the cycle after done -> second load completes correctly.
